// File: rtl/ps2_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_decoder_pkg
// Description : Shared definitions for the PS/2 Set-2 scan-code decoder.
//               Scan-code constants, decoder FSM encoding, ASCII control
//               characters and a status-byte classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_scan_decoder_pkg;

  // Framing and special scan codes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Modifier and control-key scan codes
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;

  // ASCII control characters
  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_ESC   = 8'h1B;

  // Decoder FSM encoding
  localparam int         ST_W       = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  // Bytes following the E1 pause prefix that are swallowed silently
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  // Keyboard-to-host status bytes that never start a key sequence
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_decoder_if
// Description : Byte-stream input and key-event output bundle of the
//               scan-code decoder.
//                 rx_done_tick/din          : byte from the PS/2 receiver
//                 key_tick/key_code/key_ext/
//                 key_break/ascii           : one decoded key event
//                 shift/ctrl/caps_lock      : live modifier state
//               master = byte source / event consumer, slave = decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scan_decoder_if;

  logic       rx_done_tick;
  logic [7:0] din;
  logic       key_tick;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] ascii;
  logic       shift;
  logic       ctrl;
  logic       caps_lock;

  modport master (
    output rx_done_tick, din,
    input  key_tick, key_code, key_ext, key_break, ascii,
    input  shift, ctrl, caps_lock
  );

  modport slave (
    input  rx_done_tick, din,
    output key_tick, key_code, key_ext, key_break, ascii,
    output shift, ctrl, caps_lock
  );

endinterface
`default_nettype wire

// File: rtl/ps2_scan_decoder_ascii_lut.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii_lut
// Description : Combinational Set-2 scan code to ASCII translation.
//   code  in  8  final scan code (prefixes stripped)
//   ext   in  1  code was E0-prefixed
//   shift in  1  shift held before this event
//   caps  in  1  caps-lock state before this event
//   ctrl  in  1  ctrl held before this event
//   ascii out 8  printable/control character, 8'h00 if none
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_lut
  import ps2_scan_decoder_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic [7:0] ascii
);

  logic [7:0] lower;   // unshifted character
  logic [7:0] upper;   // shifted character (non-letters only)
  logic       letter;  // letters follow shift XOR caps and ctrl masking

  always_comb begin
    lower  = ASC_NUL;
    upper  = ASC_NUL;
    letter = 1'b0;
    case (code)
      // letters: only the lowercase form is stored
      8'h1C: begin lower = 8'h61; letter = 1'b1; end
      8'h32: begin lower = 8'h62; letter = 1'b1; end
      8'h21: begin lower = 8'h63; letter = 1'b1; end
      8'h23: begin lower = 8'h64; letter = 1'b1; end
      8'h24: begin lower = 8'h65; letter = 1'b1; end
      8'h2B: begin lower = 8'h66; letter = 1'b1; end
      8'h34: begin lower = 8'h67; letter = 1'b1; end
      8'h33: begin lower = 8'h68; letter = 1'b1; end
      8'h43: begin lower = 8'h69; letter = 1'b1; end
      8'h3B: begin lower = 8'h6A; letter = 1'b1; end
      8'h42: begin lower = 8'h6B; letter = 1'b1; end
      8'h4B: begin lower = 8'h6C; letter = 1'b1; end
      8'h3A: begin lower = 8'h6D; letter = 1'b1; end
      8'h31: begin lower = 8'h6E; letter = 1'b1; end
      8'h44: begin lower = 8'h6F; letter = 1'b1; end
      8'h4D: begin lower = 8'h70; letter = 1'b1; end
      8'h15: begin lower = 8'h71; letter = 1'b1; end
      8'h2D: begin lower = 8'h72; letter = 1'b1; end
      8'h1B: begin lower = 8'h73; letter = 1'b1; end
      8'h2C: begin lower = 8'h74; letter = 1'b1; end
      8'h3C: begin lower = 8'h75; letter = 1'b1; end
      8'h2A: begin lower = 8'h76; letter = 1'b1; end
      8'h1D: begin lower = 8'h77; letter = 1'b1; end
      8'h22: begin lower = 8'h78; letter = 1'b1; end
      8'h35: begin lower = 8'h79; letter = 1'b1; end
      8'h1A: begin lower = 8'h7A; letter = 1'b1; end
      // digit row
      8'h45: begin lower = 8'h30; upper = 8'h29; end  // 0 )
      8'h16: begin lower = 8'h31; upper = 8'h21; end  // 1 !
      8'h1E: begin lower = 8'h32; upper = 8'h40; end  // 2 @
      8'h26: begin lower = 8'h33; upper = 8'h23; end  // 3 #
      8'h25: begin lower = 8'h34; upper = 8'h24; end  // 4 $
      8'h2E: begin lower = 8'h35; upper = 8'h25; end  // 5 %
      8'h36: begin lower = 8'h36; upper = 8'h5E; end  // 6 ^
      8'h3D: begin lower = 8'h37; upper = 8'h26; end  // 7 &
      8'h3E: begin lower = 8'h38; upper = 8'h2A; end  // 8 *
      8'h46: begin lower = 8'h39; upper = 8'h28; end  // 9 (
      // punctuation
      8'h0E: begin lower = 8'h60; upper = 8'h7E; end  // ` ~
      8'h4E: begin lower = 8'h2D; upper = 8'h5F; end  // - _
      8'h55: begin lower = 8'h3D; upper = 8'h2B; end  // = +
      8'h5D: begin lower = 8'h5C; upper = 8'h7C; end  // \ |
      8'h54: begin lower = 8'h5B; upper = 8'h7B; end  // [ {
      8'h5B: begin lower = 8'h5D; upper = 8'h7D; end  // ] }
      8'h4C: begin lower = 8'h3B; upper = 8'h3A; end  // ; :
      8'h52: begin lower = 8'h27; upper = 8'h22; end  // ' "
      8'h41: begin lower = 8'h2C; upper = 8'h3C; end  // , <
      8'h49: begin lower = 8'h2E; upper = 8'h3E; end  // . >
      8'h4A: begin lower = 8'h2F; upper = 8'h3F; end  // / ?
      // whitespace and control keys ignore shift
      SC_SPACE: begin lower = ASC_SPACE; upper = ASC_SPACE; end
      SC_ENTER: begin lower = ASC_CR;    upper = ASC_CR;    end
      SC_BKSP:  begin lower = ASC_BS;    upper = ASC_BS;    end
      SC_TAB:   begin lower = ASC_TAB;   upper = ASC_TAB;   end
      SC_ESC:   begin lower = ASC_ESC;   upper = ASC_ESC;   end
      default: ;
    endcase
  end

  always_comb begin
    ascii = ASC_NUL;
    if (ext) begin
      // keypad enter is the only extended key with a character
      ascii = (code == SC_ENTER) ? ASC_CR : ASC_NUL;
    end else if (letter) begin
      if (ctrl)
        ascii = lower & 8'h1F;
      else if (shift ^ caps)
        ascii = lower - 8'h20;
      else
        ascii = lower;
    end else begin
      ascii = shift ? upper : lower;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_decoder
// Description : PS/2 Set-2 scan-code decoder. Frames E0/F0/E1 sequences,
//               drops status bytes, times out stalled sequences, tracks
//               shift/ctrl/caps-lock and emits one registered key event
//               (with ASCII) per completed make/break sequence.
//   clk      in  1  system clock, rising edge
//   reset_n  in  1  asynchronous reset, active-low
//   bus      slave  byte input and key-event / modifier outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_decoder
  import ps2_scan_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int TO_W           = 22
) (
  input  logic                clk,
  input  logic                reset_n,
  ps2_scan_decoder_if.slave   bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [ST_W-1:0] state, state_nxt;
  logic [2:0]      skip_cnt, skip_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  logic            emit, emit_ext, emit_brk;
  logic [7:0]      lut_ascii;

  logic            key_tick_q, key_ext_q, key_break_q;
  logic [7:0]      key_code_q, ascii_q;
  logic            lshift, rshift, lctrl, rctrl;
  logic            caps_lock_q, caps_held;

  logic            rx;
  logic [7:0]      din;

  assign rx  = bus.rx_done_tick;
  assign din = bus.din;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = !rx && (state != ST_IDLE) && (to_cnt == TO_LAST);

  // --------------------------------------------------------------------
  // Sequence framing
  // --------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    if (rx) begin
      case (state)
        ST_IDLE: begin
          if (din == SC_EXT) begin
            state_nxt = ST_EXT;
          end else if (din == SC_BRK) begin
            state_nxt = ST_BRK;
          end else if (din == SC_PAUSE) begin
            state_nxt = ST_SKIP;
            skip_nxt  = PAUSE_TAIL;
          end else if (!is_status_byte(din)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (din == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            state_nxt = ST_IDLE;
            emit      = 1'b1;
            emit_ext  = 1'b1;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          // a second prefix after F0 is malformed: drop the sequence
          if (din != SC_EXT && din != SC_BRK) begin
            emit     = 1'b1;
            emit_ext = (state == ST_EXT_BRK);
            emit_brk = 1'b1;
          end
        end
        ST_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      if (rx || timeout || state == ST_IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------
  // ASCII translation uses modifier state from before this event
  // --------------------------------------------------------------------
  ps2_ascii_lut u_ascii_lut (
    .code  (din),
    .ext   (emit_ext),
    .shift (lshift | rshift),
    .caps  (caps_lock_q),
    .ctrl  (lctrl | rctrl),
    .ascii (lut_ascii)
  );

  // --------------------------------------------------------------------
  // Registered event outputs and modifier tracking
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_tick_q  <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      ascii_q     <= 8'h00;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      lctrl       <= 1'b0;
      rctrl       <= 1'b0;
      caps_lock_q <= 1'b0;
      caps_held   <= 1'b0;
    end else begin
      key_tick_q <= emit;
      if (emit) begin
        key_code_q  <= din;
        key_ext_q   <= emit_ext;
        key_break_q <= emit_brk;
        ascii_q     <= emit_brk ? ASC_NUL : lut_ascii;
        if (!emit_ext) begin
          if (din == SC_LSHIFT) lshift <= !emit_brk;
          if (din == SC_RSHIFT) rshift <= !emit_brk;
          if (din == SC_CTRL)   lctrl  <= !emit_brk;
          if (din == SC_CAPS) begin
            if (emit_brk) begin
              caps_held <= 1'b0;
            end else if (!caps_held) begin
              // typematic repeats arrive with caps_held set and are ignored
              caps_lock_q <= !caps_lock_q;
              caps_held   <= 1'b1;
            end
          end
        end else if (din == SC_CTRL) begin
          rctrl <= !emit_brk;
        end
      end
    end
  end

  assign bus.key_tick  = key_tick_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_break = key_break_q;
  assign bus.ascii     = ascii_q;
  assign bus.shift     = lshift | rshift;
  assign bus.ctrl      = lctrl | rctrl;
  assign bus.caps_lock = caps_lock_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scan_decoder
// Description : Self-checking bench for ps2_scan_decoder. Expected key
//               events are queued as bytes are sent and compared when the
//               decoder emits key_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_decoder;

  localparam int T  = 40;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ps2_scan_decoder_if ifc ();

  ps2_scan_decoder #(
    .TIMEOUT_CYCLES (T),
    .TO_W           (TW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] asc;
    logic       sh;
    logic       ct;
    logic       cp;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_ev(input logic [7:0] c, input logic e, input logic b,
                        input logic [7:0] a, input logic s, input logic ct,
                        input logic cp);
    ev_t x;
    x.code = c; x.ext = e; x.brk = b; x.asc = a;
    x.sh = s; x.ct = ct; x.cp = cp;
    sb.push_back(x);
  endtask

  // called at a negedge; leaves rx high across exactly one rising edge
  task automatic send(input logic [7:0] b);
    ifc.rx_done_tick = 1'b1;
    ifc.din          = b;
    @(negedge clk);
    ifc.rx_done_tick = 1'b0;
    ifc.din          = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    idle(3);
    check_val(tag, sb.size(), 0);
  endtask

  // scoreboard compare on every emitted event
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ifc.key_tick === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_tick", ifc.key_tick, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check_val("key_code",  ifc.key_code,  mon_e.code);
        check_val("key_ext",   ifc.key_ext,   mon_e.ext);
        check_val("key_break", ifc.key_break, mon_e.brk);
        check_val("ascii",     ifc.ascii,     mon_e.asc);
        check_val("shift",     ifc.shift,     mon_e.sh);
        check_val("ctrl",      ifc.ctrl,      mon_e.ct);
        check_val("caps_lock", ifc.caps_lock, mon_e.cp);
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_cleared(input string tag);
    check_val({tag, "_tick"},  ifc.key_tick,  1'b0);
    check_val({tag, "_code"},  ifc.key_code,  8'h00);
    check_val({tag, "_ext"},   ifc.key_ext,   1'b0);
    check_val({tag, "_brk"},   ifc.key_break, 1'b0);
    check_val({tag, "_ascii"}, ifc.ascii,     8'h00);
    check_val({tag, "_shift"}, ifc.shift,     1'b0);
    check_val({tag, "_ctrl"},  ifc.ctrl,      1'b0);
    check_val({tag, "_caps"},  ifc.caps_lock, 1'b0);
  endtask

  initial begin
    ifc.rx_done_tick = 1'b0;
    ifc.din          = 8'h00;
    reset_n          = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // plain make
    exp_ev(8'h1C, 0, 0, 8'h61, 0, 0, 0); send(8'h1C);
    drained("t1_drain");

    // shift make/break around letters
    exp_ev(8'h12, 0, 0, 8'h00, 1, 0, 0); send(8'h12);
    exp_ev(8'h1C, 0, 0, 8'h41, 1, 0, 0); send(8'h1C);
    exp_ev(8'h1C, 0, 1, 8'h00, 1, 0, 0); send(8'hF0); send(8'h1C);
    exp_ev(8'h12, 0, 1, 8'h00, 0, 0, 0); send(8'hF0); send(8'h12);
    exp_ev(8'h1C, 0, 0, 8'h61, 0, 0, 0); send(8'h1C);
    drained("t2_drain");

    // caps lock toggles once despite typematic repeats
    exp_ev(8'h58, 0, 0, 8'h00, 0, 0, 1); send(8'h58);
    exp_ev(8'h58, 0, 0, 8'h00, 0, 0, 1); send(8'h58);
    exp_ev(8'h58, 0, 0, 8'h00, 0, 0, 1); send(8'h58);
    exp_ev(8'h58, 0, 1, 8'h00, 0, 0, 1); send(8'hF0); send(8'h58);
    exp_ev(8'h1C, 0, 0, 8'h41, 0, 0, 1); send(8'h1C);
    exp_ev(8'h12, 0, 0, 8'h00, 1, 0, 1); send(8'h12);
    exp_ev(8'h1C, 0, 0, 8'h61, 1, 0, 1); send(8'h1C);
    exp_ev(8'h12, 0, 1, 8'h00, 0, 0, 1); send(8'hF0); send(8'h12);
    exp_ev(8'h16, 0, 0, 8'h31, 0, 0, 1); send(8'h16);
    exp_ev(8'h12, 0, 0, 8'h00, 1, 0, 1); send(8'h12);
    exp_ev(8'h16, 0, 0, 8'h21, 1, 0, 1); send(8'h16);
    exp_ev(8'h12, 0, 1, 8'h00, 0, 0, 1); send(8'hF0); send(8'h12);
    drained("t3_drain");

    // extended keys, right ctrl, control codes, whitespace keys
    exp_ev(8'h75, 1, 1, 8'h00, 0, 0, 1); send(8'hE0); send(8'hF0); send(8'h75);
    exp_ev(8'h14, 1, 0, 8'h00, 0, 1, 1); send(8'hE0); send(8'h14);
    exp_ev(8'h21, 0, 0, 8'h03, 0, 1, 1); send(8'h21);
    exp_ev(8'h14, 1, 1, 8'h00, 0, 0, 1); send(8'hE0); send(8'hF0); send(8'h14);
    exp_ev(8'h5A, 1, 0, 8'h0D, 0, 0, 1); send(8'hE0); send(8'h5A);
    exp_ev(8'h29, 0, 0, 8'h20, 0, 0, 1); send(8'h29);
    exp_ev(8'h66, 0, 0, 8'h08, 0, 0, 1); send(8'h66);
    exp_ev(8'h0D, 0, 0, 8'h09, 0, 0, 1); send(8'h0D);
    exp_ev(8'h76, 0, 0, 8'h1B, 0, 0, 1); send(8'h76);
    exp_ev(8'h4E, 0, 0, 8'h2D, 0, 0, 1); send(8'h4E);
    drained("t4_drain");

    // protocol errors and status bytes produce nothing
    send(8'hF0); send(8'hE0);
    send(8'hF0); send(8'hF0);
    send(8'hFA); send(8'hFE); send(8'hEE); send(8'h00); send(8'hFF);
    exp_ev(8'h1C, 0, 0, 8'h41, 0, 0, 1); send(8'h1C);
    drained("err_drain");

    // timeout: full expiry drops the prefix, byte at expiry keeps it
    send(8'hE0); idle(T);
    exp_ev(8'h1C, 0, 0, 8'h41, 0, 0, 1); send(8'h1C);
    drained("to_expired");
    send(8'hE0); idle(T - 1);
    exp_ev(8'h1C, 1, 0, 8'h00, 0, 0, 1); send(8'h1C);
    drained("to_at_expiry");

    // pause sequence and BAT are swallowed
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hAA);
    exp_ev(8'h29, 0, 0, 8'h20, 0, 0, 1); send(8'h29);
    drained("pause_drain");

    // reset mid-sequence
    send(8'hE0);
    reset_n = 1'b0;
    #1;
    check_cleared("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_ev(8'h1C, 0, 0, 8'h61, 0, 0, 0); send(8'h1C);
    drained("rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
